// File: rtl/cache_fill_pkg.sv
// Shared types and constants for the cache miss-fill controller.
// Critical-word-first ordering is selected in the controller with CACHE_FILL_CWF_EN.
package cache_fill_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } fill_state_e;

   localparam int DEFAULT_WORDS_PER_BLOCK = 8;

   // Clears the word offset and the byte-in-word bit of a 16-bit byte address
   localparam logic [15:0] BLOCK_OFFSET_MASK = 16'hFFFF << ($clog2(DEFAULT_WORDS_PER_BLOCK) + 1);

endpackage

// File: rtl/fill_offset_counter.sv
// Wrapping word-offset counter with a load port; tracks how many increments
// have happened since the last load so a full block can be detected.
module fill_offset_counter
   import cache_fill_pkg::*;
#(
   parameter int WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK,
   parameter int OFF_W           = $clog2(WORDS_PER_BLOCK)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [OFF_W-1:0] start_i,
   input  logic             en_i,
   output logic [OFF_W-1:0] offset_o,
   output logic             done_o,
   output logic             last_o
);

   localparam logic [OFF_W:0] FULL_COUNT = (OFF_W + 1)'(WORDS_PER_BLOCK);
   localparam logic [OFF_W:0] LAST_COUNT = (OFF_W + 1)'(WORDS_PER_BLOCK - 1);

   logic [OFF_W-1:0] offset_q, offset_d;
   logic [OFF_W:0]   count_q, count_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         offset_q <= '0;
         count_q  <= '0;
      end else begin
         offset_q <= offset_d;
         count_q  <= count_d;
      end
   end

   // The offset wraps naturally because the block size is a power of two
   always_comb begin
      offset_d = offset_q;
      count_d  = count_q;
      if (load_i) begin
         offset_d = start_i;
         count_d  = '0;
      end else if (en_i && !done_o) begin
         offset_d = offset_q + 1'b1;
         count_d  = count_q + 1'b1;
      end
   end

   assign offset_o = offset_q;
   assign done_o   = (count_q == FULL_COUNT);
   assign last_o   = (count_q == LAST_COUNT);

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-service controller: grants the shared memory to one cache (I first) and
// streams a block fill. Define CACHE_FILL_CWF_EN for critical-word-first order.
module cache_fill_ctrl
   import cache_fill_pkg::*;
#(
   parameter int WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK,
   parameter int MEM_LATENCY     = 4,
   parameter int OFF_W           = $clog2(WORDS_PER_BLOCK)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             I_miss,
   input  logic             D_miss,
   input  logic [15:0]      I_miss_addr,
   input  logic [15:0]      D_miss_addr,
   input  logic             memory_data_valid,
   output logic             mem_en,
   output logic [15:0]      memory_address,
   output logic             fsm_busy,
   output logic             grant_I,
   output logic             grant_D,
   output logic             write_data_array,
   output logic             write_tag_array,
   output logic [OFF_W-1:0] fill_offset
);

   localparam logic [15:0] BASE_MASK     = 16'hFFFF << (OFF_W + 1);
   localparam int          unusedLatency = MEM_LATENCY;

   fill_state_e      state_q, state_d;
   logic [15:0]      missAddr_q, missAddr_d;
   logic             grantI_q, grantI_d;
   logic             grantD_q, grantD_d;

   logic [15:0]      selAddr;
   logic [15:0]      issueByteOffset;
   logic [OFF_W-1:0] startOffset;
   logic [OFF_W-1:0] issueOffset;
   logic [OFF_W-1:0] recvOffset;
   logic             loadCounters;
   logic             issueEn;
   logic             recvEn;
   logic             issueDone;
   logic             recvDone;
   logic             recvLast;
   logic             unusedIssueLast;

   assign selAddr = I_miss ? I_miss_addr : D_miss_addr;

`ifdef CACHE_FILL_CWF_EN
   assign startOffset = selAddr[OFF_W:1];
`else
   assign startOffset = '0;
`endif

   assign issueByteOffset = {{(15 - OFF_W){1'b0}}, issueOffset, 1'b0};

   fill_offset_counter #(
      .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
      .OFF_W           (OFF_W)
   ) issueCounter (
      .clk      (clk),
      .rst      (rst),
      .load_i   (loadCounters),
      .start_i  (startOffset),
      .en_i     (issueEn),
      .offset_o (issueOffset),
      .done_o   (issueDone),
      .last_o   (unusedIssueLast)
   );

   fill_offset_counter #(
      .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
      .OFF_W           (OFF_W)
   ) recvCounter (
      .clk      (clk),
      .rst      (rst),
      .load_i   (loadCounters),
      .start_i  (startOffset),
      .en_i     (recvEn),
      .offset_o (recvOffset),
      .done_o   (recvDone),
      .last_o   (recvLast)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         missAddr_q <= '0;
         grantI_q   <= 1'b0;
         grantD_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         missAddr_q <= missAddr_d;
         grantI_q   <= grantI_d;
         grantD_q   <= grantD_d;
      end
   end

   // Counters reload every idle cycle so they hold the right start offset
   // on the cycle a miss is accepted; misses are only looked at in IDLE.
   always_comb begin
      state_d          = state_q;
      missAddr_d       = missAddr_q;
      grantI_d         = grantI_q;
      grantD_d         = grantD_q;
      loadCounters     = 1'b0;
      issueEn          = 1'b0;
      recvEn           = 1'b0;
      mem_en           = 1'b0;
      memory_address   = '0;
      fsm_busy         = 1'b0;
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
      fill_offset      = '0;

      case (state_q)
         IDLE: begin
            loadCounters = 1'b1;
            grantI_d     = 1'b0;
            grantD_d     = 1'b0;
            if (I_miss) begin
               missAddr_d = I_miss_addr;
               grantI_d   = 1'b1;
               state_d    = FILL;
            end else if (D_miss) begin
               missAddr_d = D_miss_addr;
               grantD_d   = 1'b1;
               state_d    = FILL;
            end
         end

         FILL: begin
            fsm_busy = 1'b1;
            if (!issueDone) begin
               mem_en         = 1'b1;
               memory_address = (missAddr_q & BASE_MASK) | issueByteOffset;
               issueEn        = 1'b1;
            end
            if (memory_data_valid && !recvDone) begin
               write_data_array = 1'b1;
               fill_offset      = recvOffset;
               recvEn           = 1'b1;
               if (recvLast) begin
                  write_tag_array = 1'b1;
                  state_d         = DONE;
               end
            end
         end

         DONE: begin
            grantI_d = 1'b0;
            grantD_d = 1'b0;
            state_d  = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign grant_I = grantI_q;
   assign grant_D = grantD_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: expected reads/writes are queued when a
// miss is driven and popped as the DUT issues them. Honours CACHE_FILL_CWF_EN.
module tb_cache_fill_ctrl;

   localparam int WPB   = 8;
   localparam int LAT   = 4;
   localparam int OFF_W = 3;

   typedef struct {
      logic [15:0] addr;
      int          cyc;
   } rdExp_t;

   typedef struct {
      int   off;
      logic tag;
      logic gI;
      logic gD;
      int   cyc;
   } wrExp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             I_miss;
   logic             D_miss;
   logic [15:0]      I_miss_addr;
   logic [15:0]      D_miss_addr;
   logic             memory_data_valid;
   logic             mem_en;
   logic [15:0]      memory_address;
   logic             fsm_busy;
   logic             grant_I;
   logic             grant_D;
   logic             write_data_array;
   logic             write_tag_array;
   logic [OFF_W-1:0] fill_offset;

   int     checkCount = 0;
   int     errorCount = 0;
   int     cycleCount = 0;
   logic   useJitter  = 1'b0;
   rdExp_t expReadQ[$];
   wrExp_t expWrQ[$];
   int     retQ[$];

   cache_fill_ctrl #(
      .WORDS_PER_BLOCK (WPB),
      .MEM_LATENCY     (LAT),
      .OFF_W           (OFF_W)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .I_miss            (I_miss),
      .D_miss            (D_miss),
      .I_miss_addr       (I_miss_addr),
      .D_miss_addr       (D_miss_addr),
      .memory_data_valid (memory_data_valid),
      .mem_en            (mem_en),
      .memory_address    (memory_address),
      .fsm_busy          (fsm_busy),
      .grant_I           (grant_I),
      .grant_D           (grant_D),
      .write_data_array  (write_data_array),
      .write_tag_array   (write_tag_array),
      .fill_offset       (fill_offset)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s at cycle %0d: observed 0x%0h, expected 0x%0h", tag, cycleCount, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic iMiss, input logic [15:0] iAddr,
                                input logic dMiss, input logic [15:0] dAddr);
      I_miss      = iMiss;
      I_miss_addr = iAddr;
      D_miss      = dMiss;
      D_miss_addr = dAddr;
   endtask

   task automatic pushFill(input logic [15:0] addr, input logic isI, input int s, input logic fixedLat);
      int          start;
      int          off;
      rdExp_t      r;
      wrExp_t      w;
      logic [15:0] base;
      base = addr & 16'hFFF0;
`ifdef CACHE_FILL_CWF_EN
      start = int'(addr[3:1]);
`else
      start = 0;
`endif
      for (int i = 0; i < WPB; i++) begin
         off    = (start + i) % WPB;
         r.addr = base | 16'(off * 2);
         r.cyc  = s + 1 + i;
         expReadQ.push_back(r);
         w.off  = off;
         w.tag  = (i == WPB - 1);
         w.gI   = isI;
         w.gD   = !isI;
         w.cyc  = fixedLat ? (s + 1 + LAT + i) : -1;
         expWrQ.push_back(w);
      end
   endtask

   task automatic monitor();
      rdExp_t r;
      wrExp_t w;
      int     t;
      if (mem_en) begin
         if (expReadQ.size() == 0) begin
            checkOutput("unexpRead", 32'(mem_en), 32'(0));
         end else begin
            r = expReadQ.pop_front();
            checkOutput("rdAddr", 32'(memory_address), 32'(r.addr));
            checkOutput("rdCycle", 32'(cycleCount), 32'(r.cyc));
            t = cycleCount + LAT + (useJitter ? int'($urandom_range(3, 0)) : 0);
            if (retQ.size() > 0 && t <= retQ[$]) t = retQ[$] + 1;
            retQ.push_back(t);
         end
      end
      if (write_data_array) begin
         if (expWrQ.size() == 0) begin
            checkOutput("unexpWrite", 32'(write_data_array), 32'(0));
         end else begin
            w = expWrQ.pop_front();
            checkOutput("wrOffset", 32'(fill_offset), 32'(w.off));
            checkOutput("wrTag", 32'(write_tag_array), 32'(w.tag));
            checkOutput("wrGrantI", 32'(grant_I), 32'(w.gI));
            checkOutput("wrGrantD", 32'(grant_D), 32'(w.gD));
            if (w.cyc >= 0) checkOutput("wrCycle", 32'(cycleCount), 32'(w.cyc));
         end
      end else begin
         checkOutput("tagAlone", 32'(write_tag_array), 32'(0));
      end
   endtask

   task automatic stepCycle();
      int dummy;
      @(negedge clk);
      if (retQ.size() > 0 && retQ[0] == cycleCount) begin
         memory_data_valid = 1'b1;
         dummy = retQ.pop_front();
      end else begin
         memory_data_valid = 1'b0;
      end
      #1;
      monitor();
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "MemEn"}, 32'(mem_en), 32'(0));
      checkOutput({tag, "Addr"}, 32'(memory_address), 32'(0));
      checkOutput({tag, "Busy"}, 32'(fsm_busy), 32'(0));
      checkOutput({tag, "GrantI"}, 32'(grant_I), 32'(0));
      checkOutput({tag, "GrantD"}, 32'(grant_D), 32'(0));
      checkOutput({tag, "WrData"}, 32'(write_data_array), 32'(0));
      checkOutput({tag, "WrTag"}, 32'(write_tag_array), 32'(0));
      checkOutput({tag, "Offset"}, 32'(fill_offset), 32'(0));
   endtask

   task automatic drain(input string tag, input int maxCycles);
      for (int n = 0; n < maxCycles; n++) begin
         if (expReadQ.size() == 0 && expWrQ.size() == 0 && retQ.size() == 0) break;
         stepCycle();
      end
      checkOutput({tag, "Pending"}, 32'(expReadQ.size() + expWrQ.size() + retQ.size()), 32'(0));
      stepCycle();
      stepCycle();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int s;
      rst = 1'b1;
      memory_data_valid = 1'b0;
      applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
      repeat (2) @(negedge clk);
      #1;
      checkAllZero("reset");
      rst = 1'b0;
      stepCycle();
      stepCycle();

      $display("[TB] D-only miss at 0x1236");
      s = cycleCount;
      applyStimulus(1'b0, 16'h0000, 1'b1, 16'h1236);
      pushFill(16'h1236, 1'b0, s, 1'b1);
      for (int rel = 1; rel <= 15; rel++) begin
         stepCycle();
         checkOutput("t1Busy", 32'(fsm_busy), 32'(rel >= 1 && rel <= 12));
         checkOutput("t1GrantD", 32'(grant_D), 32'(rel >= 1 && rel <= 13));
         checkOutput("t1GrantI", 32'(grant_I), 32'(0));
         applyStimulus(1'b0, 16'h0000, rel < 13, 16'h1236);
      end
      drain("t1", 50);

      $display("[TB] Simultaneous I 0x0040 and D 0x8000");
      s = cycleCount;
      applyStimulus(1'b1, 16'h0040, 1'b1, 16'h8000);
      pushFill(16'h0040, 1'b1, s, 1'b1);
      pushFill(16'h8000, 1'b0, s + 14, 1'b1);
      for (int rel = 1; rel <= 29; rel++) begin
         stepCycle();
         checkOutput("t2GrantI", 32'(grant_I), 32'(rel >= 1 && rel <= 13));
         checkOutput("t2GrantD", 32'(grant_D), 32'(rel >= 15 && rel <= 27));
         applyStimulus(rel <= 12, 16'h0040, rel <= 14, 16'h8000);
      end
      drain("t2", 50);

      $display("[TB] Miss at 0x123C");
      s = cycleCount;
      applyStimulus(1'b1, 16'h123C, 1'b0, 16'h0000);
      pushFill(16'h123C, 1'b1, s, 1'b1);
      for (int rel = 1; rel <= 15; rel++) begin
         stepCycle();
         applyStimulus(rel <= 12, 16'h123C, 1'b0, 16'h0000);
      end
      drain("t4", 50);

      $display("[TB] Address change and I miss during D fill");
      s = cycleCount;
      applyStimulus(1'b0, 16'h0000, 1'b1, 16'h2468);
      pushFill(16'h2468, 1'b0, s, 1'b1);
      pushFill(16'h7770, 1'b1, s + 14, 1'b1);
      for (int rel = 1; rel <= 30; rel++) begin
         stepCycle();
         applyStimulus(rel >= 3 && rel <= 26, (rel >= 3) ? 16'h7770 : 16'h0000,
                       rel < 13, (rel >= 3) ? 16'h5550 : 16'h2468);
      end
      drain("t3", 50);

      $display("[TB] Reset in the middle of a fill");
      s = cycleCount;
      applyStimulus(1'b0, 16'h0000, 1'b1, 16'h3000);
      pushFill(16'h3000, 1'b0, s, 1'b1);
      for (int rel = 1; rel <= 6; rel++) begin
         stepCycle();
         applyStimulus(1'b0, 16'h0000, 1'b0, 16'h3000);
      end
      checkOutput("t5BusyBefore", 32'(fsm_busy), 32'(1));
      rst = 1'b1;
      #1;
      checkAllZero("t5Rst");
      expReadQ.delete();
      expWrQ.delete();
      retQ.delete();
      #1;
      rst = 1'b0;
      retQ.push_back(s + 7);
      retQ.push_back(s + 8);
      retQ.push_back(s + 9);
      for (int rel = 7; rel <= 10; rel++) begin
         stepCycle();
         checkOutput("t5Busy", 32'(fsm_busy), 32'(0));
         checkOutput("t5WrData", 32'(write_data_array), 32'(0));
         checkOutput("t5MemEn", 32'(mem_en), 32'(0));
      end

      $display("[TB] Irregular memory latency");
      useJitter = 1'b1;
      s = cycleCount;
      applyStimulus(1'b0, 16'h0000, 1'b1, 16'h4A52);
      pushFill(16'h4A52, 1'b0, s, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 16'h0000, 1'b0, 16'h4A52);
      drain("t6", 100);
      useJitter = 1'b0;
      checkOutput("t6Busy", 32'(fsm_busy), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
